// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Function : Instruction-fetch stage. Holds the PC, fetches over a ready
//            handshake, issues one instruction at a time and resolves the
//            next PC from the branch code, ccc field and ALU flags.
//            Optional perf counters are enabled by FETCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rdy,
  input  logic [15:0]       imem_data,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  input  logic [1:0]        branch,
  input  logic [2:0]        flags,
  input  logic [15:0]       rs_data,
  input  logic              stall,
  output logic              halt
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_issued,
  output logic [15:0]       perf_taken
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       r_instr;
  logic [15:0]       w_instr_nxt;
  logic [ADDR_W-1:0] w_pc_plus2;
  logic [ADDR_W-1:0] w_rel_tgt;
  logic [ADDR_W-1:0] w_rs_tgt;
  logic              w_cond;
  logic              w_issue_exit;
  logic              w_taken;
  logic              w_z;
  logic              w_v;
  logic              w_n;

  assign w_z = flags[2];
  assign w_v = flags[1];
  assign w_n = flags[0];

  assign w_pc_plus2 = r_pc + ADDR_W'(2);
  // 9-bit signed word offset, converted to a byte offset relative to pc+2
  assign w_rel_tgt  = w_pc_plus2 + {{(ADDR_W-10){r_instr[8]}}, r_instr[8:0], 1'b0};
  assign w_rs_tgt   = ADDR_W'(rs_data);

  always_comb begin
    w_cond = 1'b0;
    case (r_instr[11:9])
      3'b000:  w_cond = !w_z;
      3'b001:  w_cond = w_z;
      3'b010:  w_cond = !w_z && !w_n;
      3'b011:  w_cond = w_n;
      3'b100:  w_cond = w_z || (!w_z && !w_n);
      3'b101:  w_cond = w_n || w_z;
      3'b110:  w_cond = w_v;
      default: w_cond = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_instr_nxt  = r_instr;
    imem_req     = 1'b0;
    instr_valid  = 1'b0;
    halt         = 1'b0;
    w_issue_exit = 1'b0;
    w_taken      = 1'b0;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          w_instr_nxt = imem_data;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (!stall) begin
          w_issue_exit = 1'b1;
          w_state_nxt  = ST_FETCH;
          w_pc_nxt     = w_pc_plus2;
          case (branch)
            2'b01: if (w_cond) begin
              w_pc_nxt = w_rel_tgt;
              w_taken  = 1'b1;
            end
            2'b10: if (w_cond) begin
              w_pc_nxt = w_rs_tgt;
              w_taken  = 1'b1;
            end
            2'b11: begin
              w_pc_nxt    = r_pc;
              w_state_nxt = ST_HALT;
            end
            default: ;
          endcase
        end
      end
      ST_HALT: halt = 1'b1;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
      r_pc    <= RESET_PC;
      r_instr <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus2  = w_pc_plus2;
  assign instr     = r_instr;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf_issued;
  logic [15:0] r_perf_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issued <= 16'h0000;
      r_perf_taken  <= 16'h0000;
    end else begin
      if (w_issue_exit) r_perf_issued <= r_perf_issued + 16'd1;
      if (w_taken)      r_perf_taken  <= r_perf_taken + 16'd1;
    end
  end

  assign perf_issued = r_perf_issued;
  assign perf_taken  = r_perf_taken;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_issue_exit ^ w_taken;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Function : Scoreboard bench for fetch_unit: directed fetch/issue vectors
//            with hand-computed PCs, checked by an independent issue monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic [1:0]  branch;
  logic [2:0]  flags;
  logic [15:0] rs_data;
  logic        stall;
  logic        halt;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_issued;
  logic [15:0] perf_taken;
`endif

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus2    (pc_plus2),
    .branch      (branch),
    .flags       (flags),
    .rs_data     (rs_data),
    .stall       (stall),
    .halt        (halt)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_issued (perf_issued),
    .perf_taken  (perf_taken)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every issuing cycle must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && instr_valid) begin
      if (q.size() == 0) begin
        chk("issue_unexpected", 32'd1, 32'd0);
      end else begin
        chk("issue_instr", {16'h0, instr}, {16'h0, q[0].instr});
        chk("issue_pc", {16'h0, pc}, {16'h0, q[0].pc});
        if (!stall) void'(q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input logic [15:0] data, input int wait_n, input logic [1:0] br,
                           input logic [2:0] flg, input logic [15:0] rs, input int stall_n,
                           input logic [15:0] exp_pc);
    exp_t e;
    int   n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk("fetch_req", {31'h0, imem_req}, 32'd1);
    chk("fetch_addr", {16'h0, imem_addr}, {16'h0, exp_pc});
    for (int i = 0; i < wait_n; i++) begin
      imem_rdy = 1'b0;
      step();
      chk("wait_req", {31'h0, imem_req}, 32'd1);
      chk("wait_addr", {16'h0, imem_addr}, {16'h0, exp_pc});
      chk("wait_valid", {31'h0, instr_valid}, 32'd0);
    end
    e.instr = data;
    e.pc    = exp_pc;
    q.push_back(e);
    imem_rdy  = 1'b1;
    imem_data = data;
    branch    = br;
    flags     = flg;
    rs_data   = rs;
    stall     = (stall_n > 0);
    step();
    imem_rdy = 1'b0;
    for (int i = 0; i < stall_n; i++) step();
    stall = 1'b0;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_rdy = 1'b0; imem_data = 16'h0000;
    branch = 2'b00; flags = 3'b000; rs_data = 16'h0000; stall = 1'b0;
    repeat (2) step();
    chk("rst_req", {31'h0, imem_req}, 32'd0);
    chk("rst_valid", {31'h0, instr_valid}, 32'd0);
    chk("rst_halt", {31'h0, halt}, 32'd0);
    chk("rst_pc", {16'h0, pc}, 32'h0000);
    chk("rst_instr", {16'h0, instr}, 32'h0000);
    rst = 1'b0;

    //        data      wait br     flags   rs        stall pc
    issue_one(16'h1234, 0, 2'b00, 3'b000, 16'h0000, 0, 16'h0000);
    issue_one(16'h5000, 3, 2'b00, 3'b000, 16'h0000, 0, 16'h0002);
    issue_one(16'h0E00, 0, 2'b10, 3'b000, 16'h0010, 0, 16'h0004);
    issue_one(16'hC3FE, 0, 2'b01, 3'b100, 16'h0000, 0, 16'h0010);
    issue_one(16'hC3FE, 1, 2'b01, 3'b000, 16'h0000, 0, 16'h000E);
    issue_one(16'hC3FE, 0, 2'b01, 3'b000, 16'h0000, 0, 16'h0010);
    issue_one(16'h0E00, 0, 2'b10, 3'b000, 16'h0400, 0, 16'h0012);
    issue_one(16'h0200, 0, 2'b10, 3'b000, 16'h1234, 0, 16'h0400);
    issue_one(16'h0E00, 0, 2'b10, 3'b000, 16'hFFFE, 0, 16'h0402);
    issue_one(16'h1111, 0, 2'b00, 3'b000, 16'h0000, 0, 16'hFFFE);
    chk("wrap_pc_plus2", {16'h0, pc_plus2}, 32'h0002);
    issue_one(16'h0E05, 0, 2'b01, 3'b000, 16'h0000, 0, 16'h0000);
    issue_one(16'h0C03, 0, 2'b01, 3'b010, 16'h0000, 0, 16'h000C);
    issue_one(16'h0401, 0, 2'b01, 3'b001, 16'h0000, 0, 16'h0014);
    issue_one(16'h0E00, 0, 2'b10, 3'b000, 16'h0021, 0, 16'h0016);
    issue_one(16'hABCD, 0, 2'b11, 3'b000, 16'h0000, 2, 16'h0021);

    chk("halt_flag", {31'h0, halt}, 32'd1);
    chk("halt_req", {31'h0, imem_req}, 32'd0);
    chk("halt_pc", {16'h0, pc}, 32'h0021);
    imem_rdy = 1'b1; imem_data = 16'hDEAD;
    repeat (2) step();
    imem_rdy = 1'b0;
    chk("halt_stays", {31'h0, halt}, 32'd1);
    chk("halt_instr_kept", {16'h0, instr}, 32'hABCD);
    chk("halt_valid", {31'h0, instr_valid}, 32'd0);

    rst = 1'b1;
    step();
    chk("rst_halt_pc", {16'h0, pc}, 32'h0000);
    chk("rst_halt_flag", {31'h0, halt}, 32'd0);
    rst = 1'b0;
    step();
    chk("boot_to_fetch", {31'h0, imem_req}, 32'd1);
    imem_rdy = 1'b1; imem_data = 16'hBEEF; rst = 1'b1;
    step();
    chk("midfetch_instr", {16'h0, instr}, 32'h0000);
    chk("midfetch_req", {31'h0, imem_req}, 32'd0);
    chk("midfetch_valid", {31'h0, instr_valid}, 32'd0);
    chk("midfetch_pc", {16'h0, pc}, 32'h0000);
    rst = 1'b0; imem_rdy = 1'b0;
    issue_one(16'h7777, 1, 2'b00, 3'b000, 16'h0000, 0, 16'h0000);
    chk("resume_pc", {16'h0, pc}, 32'h0002);
    repeat (3) step();
    chk("queue_empty", q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
